// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock.
// Start/busy/done handshake; results hold until the next division completes.
module seq_divider16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   r, q, d;
    logic [CNT_W-1:0]   cnt;
    logic               dz;
    logic               accept;
    logic               finish;
    logic               busy_nxt;
    logic               done_nxt;
    logic [WIDTH-1:0]   r_sh, q_sh;
    logic [WIDTH:0]     diff;

    assign accept = start && (state != RUN);
    assign finish = (state == RUN) && (cnt == LAST);

    // Trial subtract as A + ~B + 1 on WIDTH+1 bits; MSB set means borrow.
    assign r_sh = {r[WIDTH-2:0], q[WIDTH-1]};
    assign q_sh = {q[WIDTH-2:0], 1'b0};
    assign diff = {1'b0, r_sh} + {1'b1, ~d} + (WIDTH+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (cnt == LAST) state_nxt = DONE;
            DONE: state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        done_nxt = finish;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    // A zero divisor skips the iterations by preloading the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r   <= '0;
            q   <= '0;
            d   <= '0;
            cnt <= '0;
            dz  <= 1'b0;
        end else if (accept) begin
            r   <= '0;
            q   <= dividend;
            d   <= divisor;
            dz  <= (divisor == '0);
            cnt <= (divisor == '0) ? LAST : '0;
        end else if (state == RUN && cnt != LAST) begin
            cnt <= cnt + 1'b1;
            if (!diff[WIDTH]) begin
                r <= diff[WIDTH-1:0];
                q <= q_sh | WIDTH'(1);
            end else begin
                r <= r_sh;
                q <= q_sh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (finish) begin
            if (dz) begin
                quotient    <= '1;
                remainder   <= q;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= q;
                remainder   <= r;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider16.sv
// Directed self-checking bench for seq_divider16.
// Inputs change after negedge or #1 after posedge; outputs sampled #1 after posedge.
module tb_seq_divider16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    seq_divider16 #(.WIDTH(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start before the next edge (E0); returns #1 after E0.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges after E0 until done is seen, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        launch(16'd100, 16'd7);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_after_e0: got %b want 1", busy);
        end
        wait_done(lat);
        n_checks++;
        if (lat !== 17) begin
            n_fail++; $display("FAIL latency_100_7: got %0d want 17", lat);
        end
        n_checks++;
        if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL result_100_7: got q=%0d r=%0d dz=%b want q=14 r=2 dz=0",
                     quotient, remainder, div_by_zero);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_at_e17: got %b want 1", busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_e18: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(16'hFFFF, 16'h0001);
        wait_done(lat);
        n_checks++;
        if (lat !== 17 || quotient !== 16'hFFFF || remainder !== 16'h0000) begin
            n_fail++;
            $display("FAIL div_ffff_1: got lat=%0d q=%h r=%h want 17 ffff 0000", lat, quotient, remainder);
        end
        start = 1'b1; dividend = 16'h1234; divisor = 16'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done);
        end
        wait_done(lat);
        n_checks++;
        if (lat !== 17 || quotient !== 16'd1 || remainder !== 16'd0) begin
            n_fail++;
            $display("FAIL div_1234_1234: got lat=%0d q=%h r=%h want 17 0001 0000", lat, quotient, remainder);
        end
    endtask

    task automatic test_bounds;
        int lat;
        launch(16'd5, 16'd10);
        wait_done(lat);
        n_checks++;
        if (quotient !== 16'd0 || remainder !== 16'd5) begin
            n_fail++; $display("FAIL div_5_10: got q=%0d r=%0d want 0 5", quotient, remainder);
        end
        launch(16'hFFFF, 16'hFFFF);
        wait_done(lat);
        n_checks++;
        if (quotient !== 16'd1 || remainder !== 16'd0) begin
            n_fail++; $display("FAIL div_ffff_ffff: got q=%0d r=%0d want 1 0", quotient, remainder);
        end
    endtask

    task automatic test_div_by_zero;
        int lat;
        launch(16'd1234, 16'd0);
        wait_done(lat);
        n_checks++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL dz_latency: got %0d want 1", lat);
        end
        n_checks++;
        if (quotient !== 16'hFFFF || remainder !== 16'd1234 || div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL dz_result: got q=%h r=%0d dz=%b want ffff 1234 1",
                     quotient, remainder, div_by_zero);
        end
        launch(16'd9, 16'd4);
        wait_done(lat);
        n_checks++;
        if (quotient !== 16'd2 || remainder !== 16'd1 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_clear: got q=%0d r=%0d dz=%b want 2 1 0", quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_ignore_start;
        int ndone;
        int at;
        logic [15:0] qs, rs;
        ndone = 0; at = 0; qs = '0; rs = '0;
        launch(16'd1000, 16'd3);
        for (int k = 1; k <= 20; k++) begin
            if (k == 5 || k == 9) begin
                start = 1'b1; dividend = 16'd77; divisor = 16'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++; at = k; qs = quotient; rs = remainder;
            end
        end
        start = 1'b0;
        n_checks++;
        if (ndone !== 1 || at !== 17) begin
            n_fail++; $display("FAIL ignore_start_pulses: got %0d done at E%0d want 1 at E17", ndone, at);
        end
        n_checks++;
        if (qs !== 16'd333 || rs !== 16'd1) begin
            n_fail++; $display("FAIL div_1000_3: got q=%0d r=%0d want 333 1", qs, rs);
        end
    endtask

    task automatic test_abort;
        int lat;
        int ndone;
        launch(16'd500, 16'd9);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b dz=%b q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", ndone);
        end
        launch(16'd500, 16'd9);
        wait_done(lat);
        n_checks++;
        if (lat !== 17 || quotient !== 16'd55 || remainder !== 16'd5) begin
            n_fail++;
            $display("FAIL div_500_9: got lat=%0d q=%0d r=%0d want 17 55 5", lat, quotient, remainder);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_bounds();
        test_div_by_zero();
        test_ignore_start();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
